// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared FSM state encoding, gate-length derivation and clog2 for the freq_meter slice.
package freq_meter_pkg;

    typedef enum logic [1:0] {IDLE, GATE, LATCH} state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int gate_cycles(input int clk_freq, input int gate_freq);
        return clk_freq / gate_freq;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer for an asynchronous input with a registered rising-edge detector.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic level_out,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_out  = sync_q[SYNC_STAGES-1];
    assign rise_pulse = level_out & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter; counts synchronized rising edges of sig_in over a
// GATE_CYCLES window and publishes the count with a one-cycle valid strobe.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CLK_IN_FREQ = 50_000_000,
    parameter int GATE_FREQ   = 1000,
    parameter int COUNT_WIDTH = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   sig_in,
    input  logic                   enable,
    output logic [COUNT_WIDTH-1:0] freq_count,
    output logic                   freq_valid,
    output logic                   overflow,
    output logic                   busy
);

    localparam int GATE_CYCLES = gate_cycles(CLK_IN_FREQ, GATE_FREQ);
    localparam int TW = clog2(GATE_CYCLES);
    localparam int WW = clog2(SYNC_STAGES + 2);
    localparam logic [TW-1:0] LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [WW-1:0] WARM_N = WW'(SYNC_STAGES + 1);

    state_e                 state_q;
    logic [TW-1:0]          timer_q;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, freq_count_q;
    logic                   ovf_flag_q, ovf_d, overflow_q, freq_valid_q, busy_q;
    logic [WW-1:0]          warm_q;
    logic                   rise, warm, sync_level_unused;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_in     (clk_in),
        .rst        (rst),
        .async_in   (sig_in),
        .level_out  (sync_level_unused),
        .rise_pulse (rise)
    );

    // Warm-up keeps the synchronizer's post-reset fill from looking like an edge.
    assign warm = (warm_q == WARM_N);

    always_comb begin
        cnt_d = (rise && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        ovf_d = ovf_flag_q | (rise & (&cnt_q));
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            cnt_q        <= '0;
            ovf_flag_q   <= 1'b0;
            warm_q       <= '0;
            freq_count_q <= '0;
            freq_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            freq_valid_q <= 1'b0;
            if (!warm) warm_q <= warm_q + 1'b1;
            case (state_q)
                IDLE: begin
                    timer_q    <= '0;
                    cnt_q      <= '0;
                    ovf_flag_q <= 1'b0;
                    if (enable && warm) begin
                        state_q <= GATE;
                        busy_q  <= 1'b1;
                    end
                end
                GATE: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q      <= cnt_d;
                        ovf_flag_q <= ovf_d;
                        timer_q    <= timer_q + 1'b1;
                        if (timer_q == LAST) state_q <= LATCH;
                    end
                end
                LATCH: begin
                    freq_count_q <= cnt_q;
                    overflow_q   <= ovf_flag_q;
                    freq_valid_q <= 1'b1;
                    timer_q      <= '0;
                    cnt_q        <= '0;
                    ovf_flag_q   <= 1'b0;
                    state_q      <= enable ? GATE : IDLE;
                    busy_q       <= enable;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign freq_count = freq_count_q;
    assign freq_valid = freq_valid_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed bench driving a 32-bit and a 3-bit freq_meter from one shared
// square-wave source, with a 100-cycle gate.
module tb_freq_meter;
    import freq_meter_pkg::*;

    localparam int GC = gate_cycles(1000, 10);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        hold = 1'b1;
    logic        gen = 1'b0;
    logic        sig;
    int          per = 0;
    int          ph = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n;
    int          seen;

    logic [31:0] cnt_a;
    logic [2:0]  cnt_b;
    logic        v_a, ov_a, busy_a, v_b, ov_b, busy_b;

    always #5 clk = ~clk;

    assign sig = (per == 0) ? hold : gen;

    freq_meter #(.CLK_IN_FREQ(1000), .GATE_FREQ(10), .COUNT_WIDTH(32), .SYNC_STAGES(2)) dut_a (
        .clk_in(clk), .rst(rst), .sig_in(sig), .enable(en),
        .freq_count(cnt_a), .freq_valid(v_a), .overflow(ov_a), .busy(busy_a)
    );

    freq_meter #(.CLK_IN_FREQ(1000), .GATE_FREQ(10), .COUNT_WIDTH(3), .SYNC_STAGES(2)) dut_b (
        .clk_in(clk), .rst(rst), .sig_in(sig), .enable(en),
        .freq_count(cnt_b), .freq_valid(v_b), .overflow(ov_b), .busy(busy_b)
    );

    // One rising edge per 'per' cycles, changing on the falling clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (per != 0) begin
                ph  = (ph + 1 >= per) ? 0 : ph + 1;
                gen = (ph < per / 2);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!v_a && cycles < budget);
        chk("valid_seen_a", 32'(v_a), 32'd1);
        chk("valid_seen_b", 32'(v_b), 32'd1);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_count", cnt_a, 32'd0);
        chk("rst_valid", 32'(v_a), 32'd0);
        chk("rst_ovf", 32'(ov_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_count_b", 32'(cnt_b), 32'd0);

        rst = 1'b0;
        en  = 1'b1;
        wait_valid(300, n);
        chk("warm_latency", 32'(n), 32'(GC + 5));
        chk("high_at_reset_a", cnt_a, 32'd0);
        chk("high_at_reset_b", 32'(cnt_b), 32'd0);
        chk("high_at_reset_ovf", 32'(ov_a), 32'd0);

        per = 10;
        @(negedge clk);
        chk("valid_one_cycle", 32'(v_a), 32'd0);
        chk("busy_continuous", 32'(busy_a), 32'd1);
        wait_valid(300, n);
        chk("spacing_after_strobe", 32'(n), 32'(GC));
        wait_valid(300, n);
        chk("spacing_p10", 32'(n), 32'(GC + 1));
        chk("p10_count_a", cnt_a, 32'd10);
        chk("p10_ovf_a", 32'(ov_a), 32'd0);
        chk("p10_count_b", 32'(cnt_b), 32'd7);
        chk("p10_ovf_b", 32'(ov_b), 32'd1);

        per = 4;
        wait_valid(300, n);
        wait_valid(300, n);
        chk("p4_count_a", cnt_a, 32'd25);
        chk("p4_ovf_a", 32'(ov_a), 32'd0);
        chk("p4_count_b", 32'(cnt_b), 32'd7);
        chk("p4_ovf_b", 32'(ov_b), 32'd1);

        per = 20;
        wait_valid(300, n);
        wait_valid(300, n);
        chk("p20_count_a", cnt_a, 32'd5);
        chk("p20_count_b", 32'(cnt_b), 32'd5);
        chk("p20_ovf_b", 32'(ov_b), 32'd0);

        repeat (50) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_valid", 32'(v_a), 32'd0);
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (v_a || v_b) seen++;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        chk("abort_count_kept", cnt_a, 32'd5);
        en = 1'b1;
        wait_valid(300, n);
        chk("reenable_latency", 32'(n), 32'(GC + 2));
        chk("reenable_count", cnt_a, 32'd5);

        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_count_a", cnt_a, 32'd0);
        chk("midrst_count_b", 32'(cnt_b), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_valid", 32'(v_a), 32'd0);
        wait_valid(300, n);
        chk("midrst_latency", 32'(n), 32'(GC + 5));
        chk("midrst_first_count", cnt_a, 32'd5);

        per  = 0;
        hold = 1'b0;
        wait_valid(300, n);
        repeat (GC - 3) @(negedge clk);
        hold = 1'b1;
        wait_valid(300, n);
        chk("last_cycle_latency", 32'(n), 32'd4);
        chk("last_cycle_edge", cnt_a, 32'd1);
        hold = 1'b0;
        repeat (GC - 2) @(negedge clk);
        hold = 1'b1;
        wait_valid(300, n);
        chk("latch_edge_latency", 32'(n), 32'd3);
        chk("latch_edge_dropped", cnt_a, 32'd0);
        wait_valid(300, n);
        chk("latch_edge_no_leak", cnt_a, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
